// File: rtl/bcd_time_entry_if.sv
// Digit-entry handshake and result bundle for the time-setting path.
// master drives digits and clear; slave is the entry block.
interface bcd_time_entry_if;
  logic       clear;
  logic       digit_valid;
  logic [3:0] digit;
  logic       digit_ready;
  logic       busy;
  logic [5:0] binary;
  logic       binary_valid;
  logic       error;

  modport master (
    output clear, digit_valid, digit,
    input  digit_ready, busy, binary, binary_valid, error
  );

  modport slave (
    input  clear, digit_valid, digit,
    output digit_ready, busy, binary, binary_valid, error
  );
endinterface

// File: rtl/bcd_time_entry.sv
// Two-digit BCD entry, range check and shift-add conversion to a 6-bit value
// for loading the seconds/minutes/hours register.
module bcd_time_entry #(
  parameter int MAX_VALUE      = 59,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic             clk,
  input logic             reset_n,
  bcd_time_entry_if.slave bus
);
  localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]     H_MAX    = 4'(MAX_VALUE / 10);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]     R_MAX    = 7'(MAX_VALUE);

  typedef enum logic [1:0] {WAIT_H, WAIT_L, CONV, OUT} state_t;

  state_t        state, nxt;
  logic [3:0]    h, l, h_n, l_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [5:0]    bin_q, bin_n;
  logic          bv_q, bv_n, err_q, err_n;
  logic          ready, acc;
  logic [6:0]    r;

  assign ready            = ((state == WAIT_H) || (state == WAIT_L)) & ~bus.clear;
  assign acc              = bus.digit_valid & ready;
  assign bus.digit_ready  = ready;
  assign bus.busy         = (state != WAIT_H);
  assign bus.binary       = bin_q;
  assign bus.binary_valid = bv_q;
  assign bus.error        = err_q;

  // h*10 + l as h*8 + h*2 + l
  assign r = 7'({h, 3'b000}) + 7'({h, 1'b0}) + 7'(l);

  always_comb begin
    nxt   = state;
    h_n   = h;
    l_n   = l;
    cnt_n = cnt;
    bin_n = bin_q;
    bv_n  = 1'b0;
    err_n = 1'b0;
    if (bus.clear) begin
      nxt   = WAIT_H;
      cnt_n = '0;
    end else begin
      case (state)
        WAIT_H: if (acc) begin
          if (bus.digit > 4'd9 || bus.digit > H_MAX) err_n = 1'b1;
          else begin
            h_n   = bus.digit;
            cnt_n = '0;
            nxt   = WAIT_L;
          end
        end
        WAIT_L: begin
          // an acceptance on the last allowed edge beats the timeout
          if (acc) begin
            if (bus.digit > 4'd9) begin
              err_n = 1'b1;
              nxt   = WAIT_H;
            end else begin
              l_n = bus.digit;
              nxt = CONV;
            end
          end else if (cnt == CNT_LAST) begin
            err_n = 1'b1;
            cnt_n = '0;
            nxt   = WAIT_H;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        CONV: begin
          if (r > R_MAX) begin
            err_n = 1'b1;
            nxt   = WAIT_H;
          end else begin
            bin_n = r[5:0];
            bv_n  = 1'b1;
            nxt   = OUT;
          end
        end
        default: nxt = WAIT_H;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT_H;
      h     <= '0;
      l     <= '0;
      cnt   <= '0;
      bin_q <= '0;
      bv_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      h     <= h_n;
      l     <= l_n;
      cnt   <= cnt_n;
      bin_q <= bin_n;
      bv_q  <= bv_n;
      err_q <= err_n;
    end
  end
endmodule

// File: tb/tb_bcd_time_entry.sv
// Bench: two parameterisations driven by one stimulus stream, each checked
// every cycle against an entry-level model, plus hand-computed spot checks.
module tb_bcd_time_entry;
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       clear = 1'b0;
  logic       dv = 1'b0;
  logic [3:0] dg = 4'd0;
  bit         started = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_time_entry_if if0 ();
  bcd_time_entry_if if1 ();

  assign if0.clear = clear;
  assign if0.digit_valid = dv;
  assign if0.digit = dg;
  assign if1.clear = clear;
  assign if1.digit_valid = dv;
  assign if1.digit = dg;

  bcd_time_entry #(.MAX_VALUE(59), .TIMEOUT_CYCLES(8)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  bcd_time_entry #(.MAX_VALUE(23), .TIMEOUT_CYCLES(5)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));

  function automatic int mx(input int k);
    return (k == 0) ? 59 : 23;
  endfunction

  function automatic int tmo(input int k);
    return (k == 0) ? 8 : 5;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: ph 0 = awaiting tens digit, 1 = awaiting units, 2 = converting, 3 = presenting.
  int ph[2], hv[2], lv[2], waited[2], bin[2], ebv[2], eerr[2];
  bit acc;

  always @(posedge clk or negedge reset_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        ph[k] = 0; hv[k] = 0; lv[k] = 0; waited[k] = 0;
        bin[k] = 0; ebv[k] = 0; eerr[k] = 0;
      end else begin
        acc = dv && (ph[k] <= 1) && !clear;
        ebv[k] = 0;
        eerr[k] = 0;
        if (clear) begin
          ph[k] = 0;
          waited[k] = 0;
        end else begin
          case (ph[k])
            0: if (acc) begin
              // a tens digit is legal only if d0 (its smallest completion) fits
              if (int'(dg) > 9 || int'(dg) * 10 > mx(k)) eerr[k] = 1;
              else begin hv[k] = int'(dg); waited[k] = 0; ph[k] = 1; end
            end
            1: if (acc) begin
              if (int'(dg) > 9) begin eerr[k] = 1; ph[k] = 0; end
              else begin lv[k] = int'(dg); ph[k] = 2; end
            end else begin
              waited[k]++;
              if (waited[k] == tmo(k)) begin eerr[k] = 1; ph[k] = 0; waited[k] = 0; end
            end
            2: begin
              if (hv[k] * 10 + lv[k] > mx(k)) begin eerr[k] = 1; ph[k] = 0; end
              else begin bin[k] = hv[k] * 10 + lv[k]; ebv[k] = 1; ph[k] = 3; end
            end
            default: ph[k] = 0;
          endcase
        end
      end
    end
  end

  task automatic cmp(input int k, input logic rdy, input logic bsy, input logic [5:0] b,
                     input logic bv, input logic er);
    chk($sformatf("u%0d.digit_ready", k), int'(rdy), int'(ph[k] <= 1 && !clear));
    chk($sformatf("u%0d.busy", k), int'(bsy), int'(ph[k] != 0));
    chk($sformatf("u%0d.binary", k), int'(b), bin[k]);
    chk($sformatf("u%0d.binary_valid", k), int'(bv), ebv[k]);
    chk($sformatf("u%0d.error", k), int'(er), eerr[k]);
  endtask

  always @(negedge clk) begin
    #1;
    if (started) begin
      cmp(0, if0.digit_ready, if0.busy, if0.binary, if0.binary_valid, if0.error);
      cmp(1, if1.digit_ready, if1.busy, if1.binary, if1.binary_valid, if1.error);
    end
  end

  task automatic put(input int d);
    dv = 1'b1;
    dg = 4'(d);
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  int mode;

  initial begin
    #2 reset_n = 1'b0;
    started = 1'b1;
    idle(2);
    reset_n = 1'b1;
    @(negedge clk); #2;
    chk("rst.binary", int'(if0.binary), 0);
    chk("rst.ready", int'(if0.digit_ready), 1);
    chk("rst.busy", int'(if0.busy), 0);
    chk("rst.valid", int'(if0.binary_valid), 0);

    // 4,2 -> 42
    put(4); put(2); #2;
    chk("t1.busy_conv", int'(if0.busy), 1);
    @(negedge clk); #2;
    chk("t1.bin42", int'(if0.binary), 42);
    chk("t1.valid", int'(if0.binary_valid), 1);
    chk("t1.busy_out", int'(if0.busy), 1);
    idle(1);
    sync_clear();

    // 5,9 then 0,0 at full rate
    put(5); put(9);
    @(negedge clk); #2;
    chk("t2.bin59", int'(if0.binary), 59);
    idle(1);
    put(0); put(0);
    @(negedge clk); #2;
    chk("t2.bin0", int'(if0.binary), 0);
    chk("t2.valid", int'(if0.binary_valid), 1);
    chk("t2.u1valid", int'(if1.binary_valid), 1);
    idle(2);

    // MAX 23 unit: 3 rejected, 24 rejected, 23 accepted
    put(3); #2;
    chk("t3.high_err", int'(if1.error), 1);
    chk("t3.high_busy", int'(if1.busy), 0);
    sync_clear();
    put(2); put(4);
    @(negedge clk); #2;
    chk("t3.range_err", int'(if1.error), 1);
    chk("t3.keep_bin", int'(if1.binary), 0);
    chk("t3.u0bin24", int'(if0.binary), 24);
    idle(1);
    put(2); put(3);
    @(negedge clk); #2;
    chk("t3.bin23", int'(if1.binary), 23);
    idle(1);

    // illegal BCD digits
    put(1); put(12); #2;
    chk("t4.low_err", int'(if0.error), 1);
    chk("t4.low_busy", int'(if0.busy), 0);
    put(10); #2;
    chk("t4.high_err", int'(if0.error), 1);
    idle(1);

    // timeout after 8 idle edges on u0
    put(3);
    idle(7); #2;
    chk("t5.no_err_yet", int'(if0.error), 0);
    chk("t5.still_busy", int'(if0.busy), 1);
    @(negedge clk); #2;
    chk("t5.timeout_err", int'(if0.error), 1);
    chk("t5.busy_drop", int'(if0.busy), 0);
    idle(1);
    put(1);
    idle(7);
    put(4); #2;
    chk("t5.edge_no_err", int'(if0.error), 0);
    @(negedge clk); #2;
    chk("t5.bin14", int'(if0.binary), 14);
    chk("t5.valid", int'(if0.binary_valid), 1);
    idle(2);

    // clear, clear with a digit, then async reset mid-entry
    put(1);
    sync_clear(); #2;
    chk("t6.clr_busy", int'(if0.busy), 0);
    clear = 1'b1; dv = 1'b1; dg = 4'd5;
    @(negedge clk);
    clear = 1'b0; dv = 1'b0; #2;
    chk("t6.clr_noacc", int'(if0.busy), 0);
    chk("t6.clr_noerr", int'(if0.error), 0);
    put(1);
    #3 reset_n = 1'b0;
    #2;
    chk("t6.rst_bin", int'(if0.binary), 0);
    chk("t6.rst_busy", int'(if0.busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    put(1); put(5);
    @(negedge clk); #2;
    chk("t6.bin15", int'(if0.binary), 15);
    chk("t6.u1bin15", int'(if1.binary), 15);
    idle(2);

    // random traffic, alternating dense and sparse phases
    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) mode = $urandom_range(0, 2);
      reset_n = ($urandom_range(0, 599) != 0);
      clear = ($urandom_range(0, 39) == 0);
      case (mode)
        0: dv = ($urandom_range(0, 9) < 8);
        1: dv = ($urandom_range(0, 19) == 0);
        default: dv = ($urandom_range(0, 1) == 1);
      endcase
      dg = ($urandom_range(0, 4) != 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    reset_n = 1'b1; clear = 1'b0; dv = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
